// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of the flash page cache: serializes byte
// reads, waits out page-miss refills, and returns each byte with a one-cycle ack.
module flash_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'h100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic [23:0] address_0,
    output logic [7:0]  data_0,
    output logic        ack_0,
    output logic        error_0,
    input  logic        req_1,
    input  logic [23:0] address_1,
    output logic [7:0]  data_1,
    output logic        ack_1,
    output logic        error_1,
    output logic [23:0] flash_address,
    output logic        flash_enable,
    input  logic [7:0]  flash_data,
    input  logic        flash_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT_BUSY,
        CAPTURE
    } state_t;

    localparam logic [3:0]  SETTLE_INIT  = 4'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t      state_q;
    logic        last_grant_q;
    logic        grant_q;
    logic        abort_q;
    logic [3:0]  settle_q;
    logic [23:0] timeout_q;
    logic [23:0] flash_address_q;
    logic        flash_enable_q;
    logic [7:0]  data_0_q, data_1_q;
    logic        ack_0_q, ack_1_q;
    logic        error_0_q, error_1_q;

    logic        grant_d;
    logic [23:0] timeout_d;

    // On a tie the port that was not served last wins; otherwise whoever asks.
    always_comb begin
        grant_d = req_1;
        if (req_0 && req_1) begin
            grant_d = ~last_grant_q;
        end
        timeout_d = timeout_q + 24'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            grant_q         <= 1'b0;
            abort_q         <= 1'b0;
            settle_q        <= '0;
            timeout_q       <= '0;
            flash_address_q <= '0;
            flash_enable_q  <= 1'b0;
            data_0_q        <= '0;
            data_1_q        <= '0;
            ack_0_q         <= 1'b0;
            ack_1_q         <= 1'b0;
            error_0_q       <= 1'b0;
            error_1_q       <= 1'b0;
        end else begin
            ack_0_q   <= 1'b0;
            ack_1_q   <= 1'b0;
            error_0_q <= 1'b0;
            error_1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_0 || req_1) begin
                        grant_q         <= grant_d;
                        flash_address_q <= grant_d ? address_1 : address_0;
                        flash_enable_q  <= 1'b1;
                        settle_q        <= SETTLE_INIT;
                        abort_q         <= 1'b0;
                        state_q         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == 4'd0) begin
                        timeout_q <= '0;
                        state_q   <= WAIT_BUSY;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (!flash_busy) begin
                        state_q <= CAPTURE;
                    end else begin
                        timeout_q <= timeout_d;
                        if (timeout_d == TIMEOUT_LAST) begin
                            abort_q <= 1'b1;
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // Cache data is registered, so it is valid here, one cycle after busy fell.
                    if (grant_q) begin
                        data_1_q  <= abort_q ? 8'hff : flash_data;
                        ack_1_q   <= 1'b1;
                        error_1_q <= abort_q;
                    end else begin
                        data_0_q  <= abort_q ? 8'hff : flash_data;
                        ack_0_q   <= 1'b1;
                        error_0_q <= abort_q;
                    end
                    flash_enable_q <= 1'b0;
                    last_grant_q   <= grant_q;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flash_address = flash_address_q;
    assign flash_enable  = flash_enable_q;
    assign data_0        = data_0_q;
    assign ack_0         = ack_0_q;
    assign error_0       = error_0_q;
    assign data_1        = data_1_q;
    assign ack_1         = ack_1_q;
    assign error_1       = error_1_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: hit, tie, miss, timeout, async reset and idle hold.
// A second instance with a short timeout is used only by the timeout scenario.
module tb_flash_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_0, req_1;
    logic [23:0] address_0, address_1;
    logic [7:0]  data_0, data_1;
    logic        ack_0, ack_1, error_0, error_1;
    logic [23:0] flash_address;
    logic        flash_enable;
    logic [7:0]  flash_data;
    logic        flash_busy;

    logic        t_req_0, t_req_1;
    logic [23:0] t_address_0, t_address_1;
    logic [7:0]  t_data_0, t_data_1;
    logic        t_ack_0, t_ack_1, t_error_0, t_error_1;
    logic [23:0] t_flash_address;
    logic        t_flash_enable;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flash_arbiter dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .address_0(address_0), .data_0(data_0), .ack_0(ack_0), .error_0(error_0),
        .req_1(req_1), .address_1(address_1), .data_1(data_1), .ack_1(ack_1), .error_1(error_1),
        .flash_address(flash_address), .flash_enable(flash_enable),
        .flash_data(flash_data), .flash_busy(flash_busy)
    );

    flash_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut_t (
        .clk(clk), .reset(reset),
        .req_0(t_req_0), .address_0(t_address_0), .data_0(t_data_0), .ack_0(t_ack_0), .error_0(t_error_0),
        .req_1(t_req_1), .address_1(t_address_1), .data_1(t_data_1), .ack_1(t_ack_1), .error_1(t_error_1),
        .flash_address(t_flash_address), .flash_enable(t_flash_enable),
        .flash_data(flash_data), .flash_busy(flash_busy)
    );

    task test_reset;
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; address_0 = '0; address_1 = '0;
        t_req_0 = 1'b0; t_req_1 = 1'b0; t_address_0 = '0; t_address_1 = '0;
        flash_data = 8'h00; flash_busy = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({flash_address, flash_enable} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_flash: got addr=%h en=%b, want 0/0", flash_address, flash_enable);
        end
        vectors++;
        if ({data_0, ack_0, error_0, data_1, ack_1, error_1} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_ports: got d0=%h a0=%b e0=%b d1=%h a1=%b e1=%b, want all 0",
                     data_0, ack_0, error_0, data_1, ack_1, error_1);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task test_hit;
        int n;
        logic got;
        flash_busy = 1'b0; flash_data = 8'h5a;
        @(negedge clk);
        req_0 = 1'b1; address_0 = 24'h001234;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                vectors++;
                if (flash_address !== 24'h001234 || flash_enable !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hit_issue: got addr=%h en=%b, want 001234/1", flash_address, flash_enable);
                end
            end
            if (ack_0) got = 1'b1;
        end
        req_0 = 1'b0;
        vectors++;
        if (!got || n != 5) begin
            miscompares++;
            $display("FAIL hit_latency: got ack at edge %0d (seen=%b), want edge 5", n, got);
        end
        vectors++;
        if (data_0 !== 8'h5a || error_0 !== 1'b0 || ack_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_data: got d0=%h e0=%b a1=%b, want 5a/0/0", data_0, error_0, ack_1);
        end
        @(posedge clk); #1;
        vectors++;
        if (ack_0 !== 1'b0 || flash_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_pulse: got ack0=%b en=%b one edge later, want 0/0", ack_0, flash_enable);
        end
    endtask

    task test_tie;
        int acks, cyc;
        logic got, prev0, prev1;
        reset = 1'b1;
        req_0 = 1'b1; req_1 = 1'b1;
        address_0 = 24'h0a0a0a; address_1 = 24'h0b0b0b;
        flash_busy = 1'b0; flash_data = 8'h11;
        @(negedge clk);
        reset = 1'b0;
        acks = 0; cyc = 0; prev0 = 1'b0; prev1 = 1'b0;
        while (acks < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if ((ack_0 && prev0) || (ack_1 && prev1) || (ack_0 && ack_1)) begin
                vectors++;
                miscompares++;
                $display("FAIL tie_pulse: got ack0=%b ack1=%b prev=%b%b, want single-cycle one-port ack",
                         ack_0, ack_1, prev0, prev1);
            end else if (ack_0 || ack_1) begin
                got = ack_1;
                vectors++;
                if (got !== acks[0]) begin
                    miscompares++;
                    $display("FAIL tie_order: ack %0d went to port %0d, want port %0d", acks, got, acks[0]);
                end
                vectors++;
                if (flash_address !== (got ? 24'h0b0b0b : 24'h0a0a0a)) begin
                    miscompares++;
                    $display("FAIL tie_addr: got %h for port %0d, want %h", flash_address, got,
                             got ? 24'h0b0b0b : 24'h0a0a0a);
                end
                vectors++;
                if ((got ? data_1 : data_0) !== 8'h11) begin
                    miscompares++;
                    $display("FAIL tie_data: got %h for port %0d, want 11", got ? data_1 : data_0, got);
                end
                acks++;
            end
            prev0 = ack_0; prev1 = ack_1;
            if (acks == 4) begin
                req_0 = 1'b0; req_1 = 1'b0;
            end else begin
                req_0 = !ack_0; req_1 = !ack_1;
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        vectors++;
        if (acks != 4) begin
            miscompares++;
            $display("FAIL tie_timeout: got %0d acks in %0d cycles, want 4", acks, cyc);
        end
        @(negedge clk);
        vectors++;
        if (ack_0 !== 1'b0 || ack_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_last_pulse: got ack0=%b ack1=%b, want 0/0", ack_0, ack_1);
        end
        repeat (3) @(negedge clk);
    endtask

    task test_miss;
        logic early;
        flash_busy = 1'b0; flash_data = 8'h3c;
        @(negedge clk);
        req_0 = 1'b1; address_0 = 24'h00abcd;
        @(negedge clk);
        flash_busy = 1'b1;
        early = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (ack_0 || ack_1) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_no_ack: got an ack while busy, want none");
        end
        flash_busy = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (ack_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_early: got ack0=%b 1 edge after busy fell, want 0", ack_0);
        end
        @(posedge clk); #1;
        vectors++;
        if (ack_0 !== 1'b1 || data_0 !== 8'h3c || error_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_ack: got ack0=%b d0=%h e0=%b 2 edges after busy fell, want 1/3c/0",
                     ack_0, data_0, error_0);
        end
        req_0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task test_timeout;
        int n;
        logic got;
        flash_busy = 1'b1; flash_data = 8'h42;
        @(negedge clk);
        t_req_1 = 1'b1; t_address_1 = 24'h00beef;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (t_ack_1) got = 1'b1;
        end
        t_req_1 = 1'b0;
        // 2 settle edges, 15 busy edges until the counter reaches 15, then capture.
        vectors++;
        if (!got || n != 19) begin
            miscompares++;
            $display("FAIL timeout_latency: got ack1 at edge %0d (seen=%b), want edge 19", n, got);
        end
        vectors++;
        if (t_error_1 !== 1'b1 || t_data_1 !== 8'hff || t_ack_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_abort: got e1=%b d1=%h a0=%b, want 1/ff/0", t_error_1, t_data_1, t_ack_0);
        end
        flash_busy = 1'b0; flash_data = 8'h77;
        @(negedge clk);
        t_req_0 = 1'b1; t_address_0 = 24'h000777;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (t_ack_0) got = 1'b1;
        end
        t_req_0 = 1'b0;
        vectors++;
        if (!got || n != 5 || t_data_0 !== 8'h77 || t_error_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_recover: got edge=%0d d0=%h e0=%b, want 5/77/0", n, t_data_0, t_error_0);
        end
        repeat (2) @(negedge clk);
    endtask

    task test_async_reset;
        int n;
        logic got, stray;
        flash_busy = 1'b1; flash_data = 8'h99;
        @(negedge clk);
        req_1 = 1'b1; address_1 = 24'h005555;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({flash_address, flash_enable} !== 25'd0) begin
            miscompares++;
            $display("FAIL async_flash: got addr=%h en=%b, want 0/0", flash_address, flash_enable);
        end
        vectors++;
        if ({data_0, ack_0, error_0, data_1, ack_1, error_1} !== 20'd0) begin
            miscompares++;
            $display("FAIL async_ports: got d0=%h a0=%b e0=%b d1=%h a1=%b e1=%b, want all 0",
                     data_0, ack_0, error_0, data_1, ack_1, error_1);
        end
        flash_busy = 1'b0;
        req_0 = 1'b1; address_0 = 24'h00aaaa;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (flash_address !== 24'h00aaaa) begin
            miscompares++;
            $display("FAIL async_tie: got addr=%h after release, want 00aaaa (port 0)", flash_address);
        end
        n = 0; got = 1'b0; stray = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack_1) stray = 1'b1;
            if (ack_0) got = 1'b1;
        end
        req_0 = 1'b0; req_1 = 1'b0;
        vectors++;
        if (!got || stray || data_0 !== 8'h99) begin
            miscompares++;
            $display("FAIL async_after: got ack0=%b stray_ack1=%b d0=%h, want 1/0/99", got, stray, data_0);
        end
        repeat (2) @(negedge clk);
    endtask

    task test_idle_hold;
        int n;
        logic got, moved, enabled;
        flash_busy = 1'b0; flash_data = 8'h30;
        @(negedge clk);
        req_0 = 1'b1; address_0 = 24'h003000;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack_0) got = 1'b1;
        end
        req_0 = 1'b0;
        vectors++;
        if (!got || data_0 !== 8'h30) begin
            miscompares++;
            $display("FAIL hold_req: got ack0=%b d0=%h, want 1/30", got, data_0);
        end
        address_0 = 24'h00ffff; address_1 = 24'h00eeee;
        moved = 1'b0; enabled = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (flash_address !== 24'h003000) moved = 1'b1;
            if (flash_enable !== 1'b0) enabled = 1'b1;
        end
        vectors++;
        if (moved !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_addr: got addr=%h during idle, want 003000", flash_address);
        end
        vectors++;
        if (enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_enable: got enable=1 during idle, want 0");
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_tie();
        test_miss();
        test_timeout();
        test_async_reset();
        test_idle_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
